// File: rtl/dds_phase_ctrl_if.sv
// rtl/dds_phase_ctrl_if.sv - waveform RAM port bundle between the DDS controller and its table RAM
interface dds_phase_ctrl_if #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 16
);
  logic                  ram_wea;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [DATA_WIDTH-1:0] ram_wr_data;
  logic [DATA_WIDTH-1:0] ram_rd_data;

  modport master (output ram_wea, ram_addr, ram_wr_data, input ram_rd_data);
  modport slave  (input ram_wea, ram_addr, ram_wr_data, output ram_rd_data);
endinterface

// File: rtl/dds_phase_ctrl.sv
// rtl/dds_phase_ctrl.sv - DDS table loader, phase accumulator and sample re-timer
// Optional phase dither LFSR enabled by defining DDS_PHASE_DITHER_EN.
`ifndef DATA_WIDTH
`define DATA_WIDTH 16
`endif
`ifndef DATA_DEPTH
`define DATA_DEPTH 1024
`endif

module dds_phase_ctrl #(
  parameter int ACC_WIDTH  = 32,
  parameter int ADDR_WIDTH = $clog2(`DATA_DEPTH),
  parameter int DATA_WIDTH = `DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_start,
  input  logic                  ld_valid,
  input  logic [DATA_WIDTH-1:0] ld_data,
  output logic                  ld_ready,
  output logic                  load_done,
  input  logic                  run_en,
  input  logic                  ftw_valid,
  input  logic [ACC_WIDTH-1:0]  ftw_in,
  input  logic [ACC_WIDTH-1:0]  phase_off,
  input  logic                  phase_sync,
  dds_phase_ctrl_if.master      ram,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  dout_valid
);

  typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

  state_t                state;
  logic [ACC_WIDTH-1:0]  acc;
  logic [ACC_WIDTH-1:0]  ftw_act;
  logic [ADDR_WIDTH-1:0] cnt;
  logic                  last_wr;
  logic                  issue_q;
  logic                  rd_vld;
  logic [ACC_WIDTH-1:0]  dith;

`ifdef DDS_PHASE_DITHER_EN
  localparam int FRAC_W = ACC_WIDTH - ADDR_WIDTH;
  localparam int DITH_W = (FRAC_W > 16) ? 16 : FRAC_W;

  logic [15:0] lfsr;

  // Galois form of x^16+x^14+x^13+x^11+1, shifting right
  always_ff @(posedge clk) begin
    if (rst)
      lfsr <= 16'hACE1;
    else if (state == RUN)
      lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
  end

  assign dith = ACC_WIDTH'(lfsr[DITH_W-1:0]);
`else
  assign dith = '0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      acc             <= '0;
      ftw_act         <= '0;
      cnt             <= '0;
      last_wr         <= 1'b0;
      issue_q         <= 1'b0;
      rd_vld          <= 1'b0;
      ld_ready        <= 1'b0;
      load_done       <= 1'b0;
      ram.ram_wea     <= 1'b0;
      ram.ram_addr    <= '0;
      ram.ram_wr_data <= '0;
      dout            <= '0;
      dout_valid      <= 1'b0;
    end else begin
      ram.ram_wea <= 1'b0;
      issue_q     <= 1'b0;
      last_wr     <= 1'b0;
      load_done   <= last_wr;

      // issue -> RAM read -> output register; in-flight samples drain after RUN ends
      rd_vld     <= issue_q;
      dout_valid <= rd_vld;
      if (rd_vld)
        dout <= ram.ram_rd_data;

      if (ftw_valid)
        ftw_act <= ftw_in;

      case (state)
        IDLE: begin
          ram.ram_addr <= '0;
          if (phase_sync)
            acc <= '0;
          if (load_start) begin
            state    <= LOAD;
            ld_ready <= 1'b1;
            cnt      <= '0;
          end else if (run_en) begin
            state <= RUN;
          end
        end

        LOAD: begin
          if (ld_valid) begin
            ram.ram_wea     <= 1'b1;
            ram.ram_addr    <= cnt;
            ram.ram_wr_data <= ld_data;
            cnt             <= cnt + 1'b1;
            if (cnt == '1) begin
              state    <= IDLE;
              ld_ready <= 1'b0;
              last_wr  <= 1'b1;
            end
          end
        end

        RUN: begin
          if (phase_sync)
            acc <= '0;
          else
            acc <= acc + ftw_act;
          if (run_en) begin
            issue_q      <= 1'b1;
            ram.ram_addr <= ADDR_WIDTH'((acc + phase_off + dith) >> (ACC_WIDTH - ADDR_WIDTH));
          end else begin
            state        <= IDLE;
            ram.ram_addr <= '0;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dds_phase_ctrl.sv
// tb/tb_dds_phase_ctrl.sv - directed self-checking bench for dds_phase_ctrl with a behavioural table RAM
module tb_dds_phase_ctrl;
  localparam int AW = 10;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          load_start = 1'b0;
  logic          ld_valid = 1'b0;
  logic [DW-1:0] ld_data = '0;
  logic          ld_ready;
  logic          load_done;
  logic          run_en = 1'b0;
  logic          ftw_valid = 1'b0;
  logic [31:0]   ftw_in = '0;
  logic [31:0]   phase_off = '0;
  logic          phase_sync = 1'b0;
  logic [DW-1:0] dout;
  logic          dout_valid;

  int passed = 0;
  int total  = 0;

  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic [DW-1:0] rd_q;

  dds_phase_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  dds_phase_ctrl #(.ACC_WIDTH(32), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk        (clk),
    .rst        (rst),
    .load_start (load_start),
    .ld_valid   (ld_valid),
    .ld_data    (ld_data),
    .ld_ready   (ld_ready),
    .load_done  (load_done),
    .run_en     (run_en),
    .ftw_valid  (ftw_valid),
    .ftw_in     (ftw_in),
    .phase_off  (phase_off),
    .phase_sync (phase_sync),
    .ram        (bus),
    .dout       (dout),
    .dout_valid (dout_valid)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.ram_wea)
      mem[bus.ram_addr] <= bus.ram_wr_data;
    rd_q <= mem[bus.ram_addr];
  end
  assign bus.ram_rd_data = rd_q;

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    total++; if (bus.ram_wea !== 1'b0) $display("FAIL rst_wea: got %0b want 0", bus.ram_wea); else passed++;
    total++; if (bus.ram_addr !== '0) $display("FAIL rst_addr: got %0d want 0", bus.ram_addr); else passed++;
    total++; if (bus.ram_wr_data !== '0) $display("FAIL rst_wr_data: got %0h want 0", bus.ram_wr_data); else passed++;
    total++; if (ld_ready !== 1'b0) $display("FAIL rst_ld_ready: got %0b want 0", ld_ready); else passed++;
    total++; if (load_done !== 1'b0) $display("FAIL rst_load_done: got %0b want 0", load_done); else passed++;
    total++; if (dout !== '0) $display("FAIL rst_dout: got %0h want 0", dout); else passed++;
    total++; if (dout_valid !== 1'b0) $display("FAIL rst_dout_valid: got %0b want 0", dout_valid); else passed++;
    rst = 1'b0;
  endtask

  // load_start and run_en together must enter LOAD; then a full 1024-word load with gaps
  task automatic test_load;
    int  sent;
    int  seen;
    int  cyc;
    int  last_cyc;
    bit  done;
    @(negedge clk);
    load_start = 1'b1; run_en = 1'b1;
    @(negedge clk);
    load_start = 1'b0; run_en = 1'b0;
    total++; if (ld_ready !== 1'b1) $display("FAIL prio_load: ld_ready got %0b want 1", ld_ready); else passed++;
    sent = 0; seen = 0; cyc = 0; last_cyc = -10; done = 0;
    while (!done && cyc < 5000) begin
      if (sent < 1024 && $urandom_range(0, 3) != 0) begin
        ld_valid = 1'b1;
        ld_data  = DW'(sent & 255);
        sent++;
      end else begin
        ld_valid = 1'b0;
      end
      @(negedge clk);
      cyc++;
      if (bus.ram_wea === 1'b1) begin
        total++;
        if (bus.ram_addr !== AW'(seen) || bus.ram_wr_data !== DW'(seen & 255))
          $display("FAIL load_wr[%0d]: got addr %0d data %0h want addr %0d data %0h",
                   seen, bus.ram_addr, bus.ram_wr_data, seen, seen & 255);
        else passed++;
        seen++;
        last_cyc = cyc;
      end
      if (load_done === 1'b1) begin
        done = 1;
        total++;
        if (cyc != last_cyc + 1 || seen != 1024)
          $display("FAIL load_done_timing: got cycle %0d writes %0d want cycle %0d writes 1024", cyc, seen, last_cyc + 1);
        else passed++;
      end
    end
    ld_valid = 1'b0;
    total++; if (!done) $display("FAIL load_timeout: got no load_done want load_done within 5000 cycles"); else passed++;
    total++; if (ld_ready !== 1'b0) $display("FAIL load_idle: ld_ready got %0b want 0", ld_ready); else passed++;
    @(negedge clk);
    total++; if (load_done !== 1'b0) $display("FAIL load_done_pulse: got %0b want 0", load_done); else passed++;
    total++; if (bus.ram_wea !== 1'b0 || bus.ram_addr !== '0)
      $display("FAIL idle_bus: got wea %0b addr %0d want 0 0", bus.ram_wea, bus.ram_addr); else passed++;
  endtask

  // ftw = 2^22: addresses 0,1,2...; dout valid two cycles after first issue with table value addr-2
  task automatic test_run;
    ftw_valid = 1'b1; ftw_in = 32'h0040_0000; phase_off = '0; phase_sync = 1'b1; run_en = 1'b1;
    @(negedge clk);
    ftw_valid = 1'b0; phase_sync = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      total++; if (bus.ram_addr !== AW'(i)) $display("FAIL run_addr[%0d]: got %0d want %0d", i, bus.ram_addr, i); else passed++;
      total++; if (dout_valid !== (i >= 2)) $display("FAIL run_valid[%0d]: got %0b want %0b", i, dout_valid, i >= 2); else passed++;
      if (i >= 2) begin
        total++; if (dout !== DW'(i - 2)) $display("FAIL run_dout[%0d]: got %0h want %0h", i, dout, i - 2); else passed++;
      end
    end
  endtask

  task automatic test_freq_change;
    int exp_a [4];
    exp_a[0] = 12; exp_a[1] = 13; exp_a[2] = 15; exp_a[3] = 17;
    ftw_valid = 1'b1; ftw_in = 32'h0080_0000;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      ftw_valid = 1'b0;
      total++; if (bus.ram_addr !== AW'(exp_a[i])) $display("FAIL freq_addr[%0d]: got %0d want %0d", i, bus.ram_addr, exp_a[i]); else passed++;
    end
    total++; if (dout !== DW'(13)) $display("FAIL freq_dout: got %0h want d", dout); else passed++;
  endtask

  // half-turn offset, then sync to zero, then 0xFFC00000 + 2^22 wraps address 1023 -> 0
  task automatic test_offset_sync_wrap;
    phase_off = 32'h8000_0000;
    @(negedge clk);
    total++; if (bus.ram_addr !== AW'(531)) $display("FAIL off_addr0: got %0d want 531", bus.ram_addr); else passed++;
    @(negedge clk);
    total++; if (bus.ram_addr !== AW'(533)) $display("FAIL off_addr1: got %0d want 533", bus.ram_addr); else passed++;
    phase_off = '0; phase_sync = 1'b1; ftw_valid = 1'b1; ftw_in = 32'hFFC0_0000;
    @(negedge clk);
    total++; if (bus.ram_addr !== AW'(23)) $display("FAIL sync_cycle_addr: got %0d want 23", bus.ram_addr); else passed++;
    phase_sync = 1'b0; ftw_in = 32'h0040_0000;
    @(negedge clk);
    ftw_valid = 1'b0;
    total++; if (bus.ram_addr !== AW'(0)) $display("FAIL sync_addr: got %0d want 0", bus.ram_addr); else passed++;
    @(negedge clk);
    total++; if (bus.ram_addr !== AW'(1023)) $display("FAIL wrap_pre: got %0d want 1023", bus.ram_addr); else passed++;
    @(negedge clk);
    total++; if (bus.ram_addr !== AW'(0)) $display("FAIL wrap_addr: got %0d want 0", bus.ram_addr); else passed++;
    @(negedge clk);
    total++; if (bus.ram_addr !== AW'(1)) $display("FAIL wrap_next: got %0d want 1", bus.ram_addr); else passed++;
    total++; if (dout !== DW'(255)) $display("FAIL wrap_dout: got %0h want ff", dout); else passed++;
  endtask

  task automatic test_stop;
    run_en = 1'b0;
    @(negedge clk);
    total++; if (dout_valid !== 1'b1 || dout !== DW'(0))
      $display("FAIL stop_tail0: got valid %0b dout %0h want 1 0", dout_valid, dout); else passed++;
    total++; if (bus.ram_addr !== '0) $display("FAIL stop_addr: got %0d want 0", bus.ram_addr); else passed++;
    @(negedge clk);
    total++; if (dout_valid !== 1'b1 || dout !== DW'(1))
      $display("FAIL stop_tail1: got valid %0b dout %0h want 1 1", dout_valid, dout); else passed++;
    @(negedge clk);
    total++; if (dout_valid !== 1'b0 || dout !== DW'(1))
      $display("FAIL stop_hold: got valid %0b dout %0h want 0 1", dout_valid, dout); else passed++;
  endtask

  // ftw = 0 in RUN: acc parked at 3*2^22, address fixed at 3, samples keep flowing
  task automatic test_ftw_zero;
    ftw_valid = 1'b1; ftw_in = '0; run_en = 1'b1;
    @(negedge clk);
    ftw_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      total++; if (bus.ram_addr !== AW'(3)) $display("FAIL zero_addr[%0d]: got %0d want 3", i, bus.ram_addr); else passed++;
      total++; if (dout_valid !== (i >= 2)) $display("FAIL zero_valid[%0d]: got %0b want %0b", i, dout_valid, i >= 2); else passed++;
      if (i >= 2) begin
        total++; if (dout !== DW'(3)) $display("FAIL zero_dout[%0d]: got %0h want 3", i, dout); else passed++;
      end
    end
    run_en = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset_mid_load;
    int extra_done;
    load_start = 1'b1;
    @(negedge clk);
    load_start = 1'b0;
    for (int i = 0; i < 300; i++) begin
      ld_valid = 1'b1;
      ld_data  = DW'(i + 256);
      @(negedge clk);
    end
    total++; if (bus.ram_wea !== 1'b1 || bus.ram_addr !== AW'(299))
      $display("FAIL mid_load_pos: got wea %0b addr %0d want 1 299", bus.ram_wea, bus.ram_addr); else passed++;
    rst = 1'b1; ld_data = DW'(556);
    @(negedge clk);
    total++; if (bus.ram_wea !== 1'b0 || bus.ram_addr !== '0 || bus.ram_wr_data !== '0)
      $display("FAIL abort_bus: got wea %0b addr %0d data %0h want 0 0 0", bus.ram_wea, bus.ram_addr, bus.ram_wr_data); else passed++;
    total++; if (ld_ready !== 1'b0 || load_done !== 1'b0)
      $display("FAIL abort_ctl: got ld_ready %0b load_done %0b want 0 0", ld_ready, load_done); else passed++;
    total++; if (dout !== '0 || dout_valid !== 1'b0)
      $display("FAIL abort_dout: got dout %0h valid %0b want 0 0", dout, dout_valid); else passed++;
    rst = 1'b0; ld_valid = 1'b0;
    extra_done = 0;
    repeat (3) begin
      @(negedge clk);
      if (load_done === 1'b1) extra_done++;
    end
    total++; if (extra_done != 0) $display("FAIL abort_no_done: got %0d pulses want 0", extra_done); else passed++;
    load_start = 1'b1;
    @(negedge clk);
    load_start = 1'b0; ld_valid = 1'b1; ld_data = 16'h00AB;
    total++; if (ld_ready !== 1'b1) $display("FAIL reload_ready: got %0b want 1", ld_ready); else passed++;
    @(negedge clk);
    ld_valid = 1'b0;
    total++; if (bus.ram_wea !== 1'b1 || bus.ram_addr !== '0 || bus.ram_wr_data !== 16'h00AB)
      $display("FAIL reload_first: got wea %0b addr %0d data %0h want 1 0 ab", bus.ram_wea, bus.ram_addr, bus.ram_wr_data); else passed++;
  endtask

  initial begin
    test_reset();
    test_load();
    test_run();
    test_freq_change();
    test_offset_sync_wrap();
    test_stop();
    test_ftw_zero();
    test_reset_mid_load();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/dds_phase_ctrl.md
Name: dds_phase_ctrl

Overview:
- Control stage directly upstream of the DDS waveform RAM (1-cycle synchronous read). Owns the RAM address, write-enable and write-data pins.
- LOAD mode: streams a new waveform table into the RAM.
- RUN mode: runs a phase accumulator, issues truncated-phase read addresses, and re-times the RAM read data into a valid-qualified sample stream.

Parameters:
- ACC_WIDTH, 32, phase accumulator width.
- ADDR_WIDTH, $clog2(`DATA_DEPTH), RAM address width; table depth = 2**ADDR_WIDTH.
- DATA_WIDTH, `DATA_WIDTH, sample width.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  synchronous reset, active-high.
- load_start  in  1  pulse; begin table load (honoured in IDLE only).
- ld_valid  in  1  load word valid.
- ld_data  in  DATA_WIDTH  load word.
- ld_ready  out  1  high in LOAD.
- load_done  out  1  1-cycle pulse after the last table word is written.
- run_en  in  1  level; 1 = run the oscillator.
- ftw_valid  in  1  pulse; capture ftw_in.
- ftw_in  in  ACC_WIDTH  frequency tuning word.
- phase_off  in  ACC_WIDTH  phase offset, sampled every cycle.
- phase_sync  in  1  pulse; clear the accumulator.
- ram_wea  out  1  RAM write enable.
- ram_addr  out  ADDR_WIDTH  RAM address.
- ram_wr_data  out  DATA_WIDTH  RAM write data.
- ram_rd_data  in  DATA_WIDTH  RAM read data, valid 1 cycle after ram_addr.
- dout  out  DATA_WIDTH  sample output.
- dout_valid  out  1  sample valid.

Behaviour:
- Reset (synchronous, rst=1): state=IDLE; acc=0; ftw_act=0; load counter=0. All outputs 0: ram_wea, ram_addr, ram_wr_data, ld_ready, load_done, dout, dout_valid. The valid pipeline is flushed. Reset mid-LOAD or mid-RUN aborts immediately; no load_done pulse.
- FSM states: IDLE, LOAD, RUN.
  - IDLE -> LOAD on load_start. load_start has priority over run_en.
  - IDLE -> RUN on run_en=1.
  - LOAD -> IDLE after the word at address 2**ADDR_WIDTH-1 is accepted. load_start and run_en are ignored during LOAD.
  - RUN -> IDLE when run_en=0. load_start is ignored in RUN.
- LOAD:
  - ld_ready=1 throughout LOAD.
  - Each cycle with ld_valid=1: ram_wea=1, ram_addr=cnt, ram_wr_data=ld_data, all registered. Then cnt++.
  - ld_valid gaps are allowed; ram_wea=0 on those cycles.
  - load_done pulses 1 cycle after the final write. cnt returns to 0.
- FTW capture:
  - ftw_valid captures ftw_in into ftw_act in any state.
  - The new value takes effect on the accumulator update of the next cycle.
- RUN:
  - Each cycle: acc <= acc + ftw_act, modulo 2**ACC_WIDTH. Wrap-around is silent.
  - phase_sync=1 forces acc <= 0 that cycle and overrides the add.
  - phase_sync is honoured in IDLE as well.
- Address and write controls:
  - In RUN: ram_addr <= upper ADDR_WIDTH bits of (acc + phase_off) mod 2**ACC_WIDTH; ram_wea=0.
  - In IDLE: ram_addr and ram_wea=0.
- Output latency and dout:
  - Latency is 2 cycles: issue flag at cycle N (ram_addr registered), ram_rd_data valid at N+1, dout/dout_valid registered at N+2.
  - dout holds its last value when dout_valid=0.
- Leaving RUN: samples already in flight still emerge with dout_valid=1. No further issue.
- ftw_act=0 in RUN: constant address, dout_valid stays 1.

Optional Feature:
- Macro: DDS_PHASE_DITHER_EN.
- Defined:
  - A 16-bit Galois LFSR (polynomial x^16+x^14+x^13+x^11+1, seed 16'hACE1 on reset) advances every RUN cycle.
  - Its low (ACC_WIDTH-ADDR_WIDTH) bits, zero-extended, are added to (acc+phase_off) before truncation. If ACC_WIDTH-ADDR_WIDTH>16, all 16 bits are used.
  - Latency unchanged.
- Undefined: no LFSR; pure truncation as above.

Test Plan:
- Load: load_start, then 1024 words with data = addr[7:0] and random ld_valid gaps -> exactly 1024 ram_wea pulses, addresses 0..1023 in order, load_done one cycle after the last write, state IDLE.
- Run: ftw=2^22, phase_off=0, run_en=1 -> ram_addr 0,1,2,…; dout_valid first high 2 cycles after the first issue; dout equals the table entry at each issued address.
- Frequency change: ftw=2^22, then ftw_valid with 2^23 mid-run -> address step changes from 1 to 2 exactly one cycle after capture.
- Offset and wrap: phase_off=2^31 -> ram_addr = previous +512 mod 1024. acc=0xFFC00000 + 2^22 -> acc=0, ram_addr wraps 1023->0.
- Sync and priority: phase_sync mid-run -> next ram_addr=0. load_start and run_en together in IDLE -> LOAD entered. run_en dropped -> two trailing valid samples, then dout_valid=0.
- Reset mid-LOAD at word 300 -> all outputs 0 next cycle, no load_done; a new load restarts at address 0.
